// File: rtl/sequencer_pkg.sv
// Shared definitions for the Mini-SRC hardwired control unit: opcodes,
// ALU function codes, instruction classes, FSM states and IR field positions.
package sequencer_pkg;

    localparam int OPC_W = 5;
    localparam int REG_W = 4;
    localparam int IR_W  = 32;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_AND  = 5'b01100;
    localparam logic [OPC_W-1:0] OPC_OR   = 5'b01101;
    localparam logic [OPC_W-1:0] OPC_MUL  = 5'b01111;
    localparam logic [OPC_W-1:0] OPC_DIV  = 5'b10000;
    localparam logic [OPC_W-1:0] OPC_NEG  = 5'b10001;
    localparam logic [OPC_W-1:0] OPC_NOT  = 5'b10010;
    localparam logic [OPC_W-1:0] OPC_NOP  = 5'b11010;
    localparam logic [OPC_W-1:0] OPC_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_MUL = 4'd4,
        ALU_DIV = 4'd5,
        ALU_NEG = 4'd6,
        ALU_NOT = 4'd7
    } alu_op_e;

    typedef enum logic [2:0] {
        CLS_NOP    = 3'd0,
        CLS_BIN    = 3'd1,
        CLS_UNARY  = 3'd2,
        CLS_MULDIV = 3'd3,
        CLS_HALT   = 3'd4
    } op_class_e;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_T0     = 4'd1,
        ST_T1     = 4'd2,
        ST_T2     = 4'd3,
        ST_T3     = 4'd4,
        ST_T4     = 4'd5,
        ST_T5     = 4'd6,
        ST_T6     = 4'd7,
        ST_HALTED = 4'd8
    } state_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: splits IR into class, ALU function and
// register fields; undefined opcodes decode as nop with the illegal flag set.
module instr_decode
    import sequencer_pkg::*;
(
    input  logic [IR_W-1:0]  ir_i,
    output logic [2:0]       op_class_o,
    output logic [3:0]       alu_op_o,
    output logic [REG_W-1:0] ra_o,
    output logic [REG_W-1:0] rb_o,
    output logic [REG_W-1:0] rc_o,
    output logic             illegal_o
);

    logic [OPC_W-1:0] opcode_s;
    logic             unused_s;

    assign opcode_s = ir_i[OPC_MSB:OPC_LSB];
    assign ra_o     = ir_i[RA_MSB:RA_LSB];
    assign rb_o     = ir_i[RB_MSB:RB_LSB];
    assign rc_o     = ir_i[RC_MSB:RC_LSB];
    assign unused_s = ^ir_i[RC_LSB-1:0];

    // Opcode to class / ALU function lookup
    always_comb begin
        op_class_o = CLS_NOP;
        alu_op_o   = ALU_ADD;
        illegal_o  = 1'b0;
        case (opcode_s)
            OPC_ADD:  begin op_class_o = CLS_BIN;    alu_op_o = ALU_ADD; end
            OPC_SUB:  begin op_class_o = CLS_BIN;    alu_op_o = ALU_SUB; end
            OPC_AND:  begin op_class_o = CLS_BIN;    alu_op_o = ALU_AND; end
            OPC_OR:   begin op_class_o = CLS_BIN;    alu_op_o = ALU_OR;  end
            OPC_MUL:  begin op_class_o = CLS_MULDIV; alu_op_o = ALU_MUL; end
            OPC_DIV:  begin op_class_o = CLS_MULDIV; alu_op_o = ALU_DIV; end
            OPC_NEG:  begin op_class_o = CLS_UNARY;  alu_op_o = ALU_NEG; end
            OPC_NOT:  begin op_class_o = CLS_UNARY;  alu_op_o = ALU_NOT; end
            OPC_NOP:  op_class_o = CLS_NOP;
            OPC_HALT: op_class_o = CLS_HALT;
            default:  illegal_o  = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Mini-SRC control unit: steps fetch T0..T2 and execute T3..T6,
// with a Run/Stop handshake, memory-ready wait in T1 and a terminal HALTED state.
module control_sequencer
    import sequencer_pkg::*;
(
    input  logic             Clock,
    input  logic             clear,
    input  logic [IR_W-1:0]  IR,
    input  logic             Run_req,
    input  logic             Stop,
    input  logic             Mem_ready,
    output logic             PCout,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             MDRout,
    output logic             MARin,
    output logic             Zin,
    output logic             PCin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             LOin,
    output logic             HIin,
    output logic             IncPC,
    output logic             Read,
    output logic             Rin,
    output logic             Rout,
    output logic [REG_W-1:0] Rsel,
    output logic [3:0]       alu_op,
    output logic             Running,
    output logic             Done,
    output logic             Illegal
);

    state_e           state_q, state_d;
    state_e           after_done_s;
    logic             t1_wait_q, t1_wait_d;
    logic             illegal_q, illegal_d;
    logic             done_s;

    logic [2:0]       dec_class_s;
    logic [3:0]       dec_alu_s;
    logic [REG_W-1:0] dec_ra_s, dec_rb_s, dec_rc_s;
    logic             dec_illegal_s;

    instr_decode u_decode (
        .ir_i       (IR),
        .op_class_o (dec_class_s),
        .alu_op_o   (dec_alu_s),
        .ra_o       (dec_ra_s),
        .rb_o       (dec_rb_s),
        .rc_o       (dec_rc_s),
        .illegal_o  (dec_illegal_s)
    );

    // State, T1-wait flag and sticky illegal flag registers
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_q   <= ST_IDLE;
            t1_wait_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            t1_wait_q <= t1_wait_d;
            illegal_q <= illegal_d;
        end
    end

    // Successor of a Done step; Stop is only looked at here
    always_comb begin
        if (dec_class_s == CLS_HALT) begin
            after_done_s = ST_HALTED;
        end else if (Run_req && !Stop) begin
            after_done_s = ST_T0;
        end else begin
            after_done_s = ST_IDLE;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        t1_wait_d = 1'b0;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (Run_req) state_d = ST_T0;
                else         state_d = ST_IDLE;
            end
            ST_T0: state_d = ST_T1;
            ST_T1: begin
                if (Mem_ready) begin
                    state_d = ST_T2;
                end else begin
                    state_d   = ST_T1;
                    t1_wait_d = 1'b1;
                end
            end
            ST_T2: state_d = ST_T3;
            ST_T3: begin
                if (dec_illegal_s) illegal_d = 1'b1;
                else               illegal_d = illegal_q;
                if (done_s) state_d = after_done_s;
                else        state_d = ST_T4;
            end
            ST_T4: begin
                if (done_s) state_d = after_done_s;
                else        state_d = ST_T5;
            end
            ST_T5: begin
                if (done_s) state_d = after_done_s;
                else        state_d = ST_T6;
            end
            ST_T6:     state_d = after_done_s;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Moore strobe decode from state and IR; only one bus driver per step
    always_comb begin
        PCout    = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        MDRout   = 1'b0;
        MARin    = 1'b0;
        Zin      = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        LOin     = 1'b0;
        HIin     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        Rsel     = {REG_W{1'b0}};
        alu_op   = 4'd0;
        Running  = 1'b0;
        done_s   = 1'b0;
        case (state_q)
            ST_T0: begin
                Running = 1'b1;
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
            end
            ST_T1: begin
                Running = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (!t1_wait_q) begin
                    Zlowout = 1'b1;
                    PCin    = 1'b1;
                end else begin
                    Zlowout = 1'b0;
                    PCin    = 1'b0;
                end
            end
            ST_T2: begin
                Running = 1'b1;
                MDRout  = 1'b1;
                IRin    = 1'b1;
            end
            ST_T3: begin
                Running = 1'b1;
                case (dec_class_s)
                    CLS_BIN:    begin Rout = 1'b1; Rsel = dec_rb_s; Yin = 1'b1; end
                    CLS_MULDIV: begin Rout = 1'b1; Rsel = dec_ra_s; Yin = 1'b1; end
                    CLS_UNARY:  begin Rout = 1'b1; Rsel = dec_rb_s; alu_op = dec_alu_s; Zin = 1'b1; end
                    default:    done_s = 1'b1;
                endcase
            end
            ST_T4: begin
                Running = 1'b1;
                case (dec_class_s)
                    CLS_BIN:    begin Rout = 1'b1; Rsel = dec_rc_s; alu_op = dec_alu_s; Zin = 1'b1; end
                    CLS_MULDIV: begin Rout = 1'b1; Rsel = dec_rb_s; alu_op = dec_alu_s; Zin = 1'b1; end
                    CLS_UNARY:  begin Zlowout = 1'b1; Rin = 1'b1; Rsel = dec_ra_s; done_s = 1'b1; end
                    default:    done_s = 1'b0;
                endcase
            end
            ST_T5: begin
                Running = 1'b1;
                case (dec_class_s)
                    CLS_BIN:    begin Zlowout = 1'b1; Rin = 1'b1; Rsel = dec_ra_s; done_s = 1'b1; end
                    CLS_MULDIV: begin Zlowout = 1'b1; LOin = 1'b1; end
                    default:    done_s = 1'b0;
                endcase
            end
            ST_T6: begin
                Running  = 1'b1;
                Zhighout = 1'b1;
                HIin     = 1'b1;
                done_s   = 1'b1;
            end
            default: Running = 1'b0;
        endcase
    end

    assign Done    = done_s;
    assign Illegal = illegal_q | ((state_q == ST_T3) & dec_illegal_s);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected strobe vectors are queued
// per cycle as stimulus is driven and compared on the following falling edge.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] IR = 32'h0;
    logic        Run_req = 1'b0;
    logic        Stop = 1'b0;
    logic        Mem_ready = 1'b1;
    logic PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin;
    logic Yin, LOin, HIin, IncPC, Read, Rin, Rout, Running, Done, Illegal;
    logic [3:0] Rsel;
    logic [3:0] alu_op;

    typedef struct packed {
        logic pcout, zlowout, zhighout, mdrout, marin, zin, pcin, mdrin;
        logic irin, yin, loin, hiin, incpc, read, rin, rout;
        logic [3:0] rsel;
        logic [3:0] alu;
        logic running, done, illegal;
    } outs_t;

    outs_t obs;
    outs_t exp_q[$];
    int    n_checks = 0;
    int    n_pass = 0;
    logic  exp_ill = 1'b0;

    control_sequencer dut (
        .Clock(Clock), .clear(clear), .IR(IR), .Run_req(Run_req), .Stop(Stop),
        .Mem_ready(Mem_ready), .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .MDRout(MDRout), .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin),
        .IRin(IRin), .Yin(Yin), .LOin(LOin), .HIin(HIin), .IncPC(IncPC), .Read(Read),
        .Rin(Rin), .Rout(Rout), .Rsel(Rsel), .alu_op(alu_op), .Running(Running),
        .Done(Done), .Illegal(Illegal)
    );

    assign obs = {PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin,
                  IRin, Yin, LOin, HIin, IncPC, Read, Rin, Rout,
                  Rsel, alu_op, Running, Done, Illegal};

    always #5 Clock = ~Clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic outs_t idle_v();
        outs_t v;
        v = '0;
        v.illegal = exp_ill;
        return v;
    endfunction

    function automatic outs_t run_v();
        outs_t v;
        v = '0;
        v.running = 1'b1;
        v.illegal = exp_ill;
        return v;
    endfunction

    task automatic cycle(input outs_t e, input string tag);
        outs_t popped;
        exp_q.push_back(e);
        @(negedge Clock);
        popped = exp_q.pop_front();
        check_val(tag, {5'b0, obs}, {5'b0, popped});
    endtask

    task automatic fetch(input logic [31:0] ir, input int waits);
        outs_t v;
        v = run_v(); v.pcout = 1'b1; v.marin = 1'b1; v.incpc = 1'b1; v.zin = 1'b1;
        cycle(v, "T0");
        IR = ir;
        v = run_v(); v.read = 1'b1; v.mdrin = 1'b1; v.zlowout = 1'b1; v.pcin = 1'b1;
        cycle(v, "T1_first");
        for (int i = 0; i < waits; i++) begin
            Mem_ready = 1'b0;
            v = run_v(); v.read = 1'b1; v.mdrin = 1'b1;
            cycle(v, "T1_wait");
        end
        Mem_ready = 1'b1;
        v = run_v(); v.mdrout = 1'b1; v.irin = 1'b1;
        cycle(v, "T2");
    endtask

    task automatic run_instr(input logic [31:0] ir, input int waits, input logic stop_t3,
                             input logic stop_done, input int abort_after);
        outs_t steps[4];
        int n, cls;
        logic [4:0] opc;
        logic [3:0] ra, rb, rc, alu;
        fetch(ir, waits);
        opc = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
        cls = 0; alu = 4'd0;
        case (opc)
            5'b00011: begin cls = 1; alu = 4'd0; end
            5'b00100: begin cls = 1; alu = 4'd1; end
            5'b01100: begin cls = 1; alu = 4'd2; end
            5'b01101: begin cls = 1; alu = 4'd3; end
            5'b01111: begin cls = 3; alu = 4'd4; end
            5'b10000: begin cls = 3; alu = 4'd5; end
            5'b10001: begin cls = 2; alu = 4'd6; end
            5'b10010: begin cls = 2; alu = 4'd7; end
            5'b11010: cls = 0;
            5'b11011: cls = 4;
            default:  begin cls = 0; exp_ill = 1'b1; end
        endcase
        for (int i = 0; i < 4; i++) steps[i] = run_v();
        case (cls)
            1: begin
                n = 3;
                steps[0].rout = 1'b1; steps[0].rsel = rb; steps[0].yin = 1'b1;
                steps[1].rout = 1'b1; steps[1].rsel = rc; steps[1].alu = alu; steps[1].zin = 1'b1;
                steps[2].zlowout = 1'b1; steps[2].rin = 1'b1; steps[2].rsel = ra; steps[2].done = 1'b1;
            end
            2: begin
                n = 2;
                steps[0].rout = 1'b1; steps[0].rsel = rb; steps[0].alu = alu; steps[0].zin = 1'b1;
                steps[1].zlowout = 1'b1; steps[1].rin = 1'b1; steps[1].rsel = ra; steps[1].done = 1'b1;
            end
            3: begin
                n = 4;
                steps[0].rout = 1'b1; steps[0].rsel = ra; steps[0].yin = 1'b1;
                steps[1].rout = 1'b1; steps[1].rsel = rb; steps[1].alu = alu; steps[1].zin = 1'b1;
                steps[2].zlowout = 1'b1; steps[2].loin = 1'b1;
                steps[3].zhighout = 1'b1; steps[3].hiin = 1'b1; steps[3].done = 1'b1;
            end
            default: begin
                n = 1;
                steps[0].done = 1'b1;
            end
        endcase
        for (int i = 0; i < n; i++) begin
            cycle(steps[i], $sformatf("exec_T%0d_op%b", i + 3, opc));
            if (abort_after == i + 1) begin
                #1 clear = 1'b0;
                #1 check_val("clear_async", {5'b0, obs}, 32'h0);
                return;
            end
            if (stop_t3) Stop = (i == 0);
        end
        Stop = stop_done;
    endtask

    initial begin
        #3 check_val("reset_outputs", {5'b0, obs}, 32'h0);
        repeat (2) @(negedge Clock);
        clear = 1'b1;
        cycle(idle_v(), "idle_no_run");
        cycle(idle_v(), "idle_no_run");

        Run_req = 1'b1;
        run_instr(32'h60918000, 0, 1'b0, 1'b0, 0);                      // and R1,R2,R3
        run_instr({5'b10001, 4'd1, 4'd3, 4'd0, 15'd0}, 3, 1'b0, 1'b0, 0); // neg R1,R3
        run_instr({5'b01111, 4'd2, 4'd3, 4'd0, 15'd0}, 0, 1'b0, 1'b0, 0); // mul R2,R3
        run_instr({5'b10000, 4'd5, 4'd6, 4'd0, 15'd0}, 1, 1'b0, 1'b0, 0); // div R5,R6
        run_instr({5'b10010, 4'd7, 4'd8, 4'd0, 15'd0}, 0, 1'b0, 1'b0, 0); // not R7,R8
        run_instr({5'b01101, 4'd9, 4'd10, 4'd11, 15'd0}, 0, 1'b0, 1'b0, 0); // or
        run_instr({5'b11010, 27'd0}, 0, 1'b0, 1'b0, 0);                  // nop
        run_instr({5'b00011, 4'd4, 4'd5, 4'd6, 15'd0}, 0, 1'b1, 1'b0, 0); // add, Stop in T3
        run_instr({5'b00100, 4'd7, 4'd8, 4'd9, 15'd0}, 0, 1'b0, 1'b1, 0); // sub, Stop at Done
        cycle(idle_v(), "stop_to_idle");
        Run_req = 1'b0;
        Stop = 1'b0;
        cycle(idle_v(), "idle_hold");

        Run_req = 1'b1;
        run_instr({5'b00011, 4'd1, 4'd2, 4'd3, 15'd0}, 0, 1'b0, 1'b0, 2); // clear in T4
        exp_ill = 1'b0;
        Run_req = 1'b0;
        @(negedge Clock);
        clear = 1'b1;
        cycle(idle_v(), "idle_after_clear");
        cycle(idle_v(), "idle_after_clear");

        Run_req = 1'b1;
        run_instr({5'b11111, 27'd0}, 0, 1'b0, 1'b0, 0);                  // undefined opcode
        check_val("illegal_sticky", {31'b0, Illegal}, 32'h1);
        run_instr({5'b11011, 27'd0}, 0, 1'b0, 1'b0, 0);                  // halt
        repeat (3) cycle(idle_v(), "halted");
        check_val("halted_not_running", {31'b0, Running}, 32'h0);

        clear = 1'b0;
        #1 check_val("clear_from_halted", {5'b0, obs}, 32'h0);
        exp_ill = 1'b0;
        Run_req = 1'b0;
        @(negedge Clock);
        clear = 1'b1;
        cycle(idle_v(), "idle_after_halt_clear");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
